// File: rtl/acc_8bits.sv
// Burst accumulator behind the 8-bit operand mux: adds or subtracts COUNT operands,
// then holds the result on a valid/ready output until it is taken.
module acc_8bits #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: an operand moves on a rising edge where in_valid && in_ready;
  // the result moves on a rising edge where out_valid && out_ready. Neither
  // ready depends combinationally on the matching valid.

  localparam int CW = ($clog2(COUNT + 1) < 1) ? 1 : $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   add_ext;
  logic             xfer;

  assign add_ext = {1'b0, sum_q} + {1'b0, in_data};
  assign xfer    = (state_q == ACCUM) && in_valid;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (xfer) begin
          if (!op) begin
            sum_d   = add_ext[WIDTH-1:0];
            carry_d = carry_q | add_ext[WIDTH];
          end else begin
            sum_d   = sum_q - in_data;
            carry_d = carry_q | (in_data > sum_q);
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status outputs decode the state register directly so reset clears them at once.
  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q == ACCUM) || (state_q == DONE);
  assign sum         = sum_q;
  assign carry       = carry_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_acc_8bits.sv
// Bench for acc_8bits: integer-arithmetic reference model checked every cycle,
// plus directed bursts with hand-computed results.
module tb_acc_8bits;

  localparam int WIDTH = 8;
  localparam int COUNT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  acc_8bits #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .sum        (sum),
    .carry      (carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 collecting, 2 result held; plain integer sums.
  int m_phase = 0;
  int m_sum   = 0;
  int m_carry = 0;
  int m_n     = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_sum = 0; m_carry = 0; m_n = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_sum = 0; m_carry = 0; m_n = 0;
        end
        1: if (in_valid) begin
          if (op == 1'b0) m_sum = m_sum + int'(in_data);
          else            m_sum = m_sum - int'(in_data);
          if (m_sum > 255) begin m_sum -= 256; m_carry = 1; end
          if (m_sum < 0)   begin m_sum += 256; m_carry = 1; end
          m_n++;
          if (m_n == COUNT) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // compare process
  always @(negedge clk) begin
    chk("cyc_in_ready",  int'(in_ready),  int'(m_phase == 1));
    chk("cyc_out_valid", int'(out_valid), int'(m_phase == 2));
    chk("cyc_busy",      int'(busy),      int'(m_phase != 0));
    chk("cyc_sum",       int'(sum),       m_sum);
    chk("cyc_carry",     int'(carry),     m_carry);
  end

  // driver: present inputs for one clock, return 1ns after the edge
  task automatic drive(input bit s, input bit v, input int d, input bit o, input bit r);
    start     = s;
    in_valid  = v;
    in_data   = WIDTH'(d);
    op        = o;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; in_valid = 0; in_data = '0; op = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", int'(sum), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle_cycle();

    // Burst 1: 100+255+39+24 = 418 -> 162 with carry
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 100, 0, 0);
    drive(0, 1, 255, 0, 0);
    drive(0, 1, 39,  0, 0);
    drive(0, 1, 24,  0, 0);
    chk("b1_out_valid_5th", int'(out_valid), 1);
    chk("b1_sum", int'(sum), 162);
    chk("b1_carry", int'(carry), 1);
    chk("b1_model_sum", m_sum, 162);
    for (int i = 0; i < 3; i++) begin
      drive(i == 1, 1, 7, 0, 0);
      chk("b1_hold_sum", int'(sum), 162);
      chk("b1_hold_in_ready", int'(in_ready), 0);
      chk("b1_hold_out_valid", int'(out_valid), 1);
    end
    drive(0, 0, 0, 0, 1);
    chk("b1_idle_out_valid", int'(out_valid), 0);

    // Burst 2: 10+20-5+1 = 26, start pulse mid-burst ignored
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 10, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 20, 0, 0);
    drive(0, 1, 5,  1, 0);
    drive(0, 1, 1,  0, 0);
    chk("b2_sum", int'(sum), 26);
    chk("b2_carry", int'(carry), 0);
    drive(0, 0, 0, 0, 1);
    chk("b2_idle_out_valid", int'(out_valid), 0);
    chk("b2_idle_sum", int'(sum), 26);
    chk("b2_idle_busy", int'(busy), 0);

    // Burst 3: in_valid alongside start consumes nothing; 0-100 borrows -> 156
    drive(1, 1, 77, 0, 0);
    drive(0, 1, 100, 1, 0);
    chk("b3_first_sum", int'(sum), 156);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("b3_sum", int'(sum), 156);
    chk("b3_carry", int'(carry), 1);
    chk("b3_out_valid", int'(out_valid), 1);
    drive(0, 0, 0, 0, 1);

    // Burst 4: gapped valids 1,0,0,1,1,0,1 -> 1+2+3+4 = 10
    drive(1, 0, 0, 0, 0);
    begin
      bit vv[7];
      int dd[7];
      vv = '{1, 0, 0, 1, 1, 0, 1};
      dd = '{1, 9, 9, 2, 3, 9, 4};
      for (int i = 0; i < 7; i++) drive(0, vv[i], dd[i], 0, 0);
    end
    chk("b4_sum", int'(sum), 10);
    chk("b4_carry", int'(carry), 0);
    chk("b4_out_valid", int'(out_valid), 1);
    drive(0, 0, 0, 0, 1);
    chk("b4_idle", int'(busy), 0);

    // Mid-burst asynchronous reset after two transfers
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 200, 0, 0);
    drive(0, 1, 100, 0, 0);
    in_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_sum", int'(sum), 0);
    chk("arst_carry", int'(carry), 0);
    chk("arst_busy", int'(busy), 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 250, 0, 0);
    drive(0, 1, 2,   0, 0);
    drive(0, 1, 3,   0, 0);
    drive(0, 1, 4,   0, 0);
    chk("post_rst_sum", int'(sum), 3);
    chk("post_rst_carry", int'(carry), 1);
    drive(0, 0, 0, 0, 1);
    chk("post_rst_idle", int'(out_valid), 0);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_8bits.md
Name: acc_8bits

Overview:
- Downstream consumer of the 8-bit 2:1 operand mux (mux_8bits); its in_data is wired to the mux output Q.
- Accumulates a burst of COUNT operands with add or subtract per operand, then presents the result over a valid/ready handshake.
- Gives the lab datapath a registered, flow-controlled result stage after the combinational select.

Parameters:
- WIDTH, 8, data width of in_data and sum; matches mux_8bits.
- COUNT, 4, number of operands accepted per burst; legal range 1..255.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse; begins a burst when in IDLE.
- in_data  input  WIDTH  operand, driven from mux_8bits Q.
- in_valid  input  1  in_data holds a valid operand this cycle.
- in_ready  output  1  block accepts an operand this cycle.
- op  input  1  0 = add in_data, 1 = subtract in_data; sampled with the operand transfer.
- sum  output  WIDTH  accumulated result, modulo 2^WIDTH.
- carry  output  1  sticky flag: any carry-out (add) or borrow (sub) during the burst.
- out_valid  output  1  sum/carry hold the final burst result.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst_n low, async): state = IDLE; sum = 0, carry = 0, operand counter = 0. Outputs in_ready = 0, out_valid = 0, busy = 0. A mid-burst reset abandons the burst; no partial result is presented.
- States: IDLE, ACCUM, DONE. Encoding is free.
- IDLE:
  - in_ready = 0.
  - start = 1 -> next ACCUM; sum <= 0, carry <= 0, counter <= 0.
  - in_valid is ignored; a start and in_valid arriving in the same cycle consume no operand.
- ACCUM:
  - in_ready = 1, busy = 1.
  - Transfer occurs when in_valid && in_ready.
  - On transfer with op = 0: sum <= sum + in_data (WIDTH bits); carry <= carry | carry-out.
  - On transfer with op = 1: sum <= sum - in_data; carry <= carry | (in_data > sum), unsigned borrow.
  - Counter increments per transfer. The transfer with counter == COUNT-1 moves the block to DONE.
  - No transfer -> hold all state. start is ignored.
- DONE:
  - in_ready = 0, out_valid = 1, busy = 1.
  - sum and carry are stable.
  - out_ready = 1 -> next IDLE, out_valid drops the following cycle.
  - out_ready low -> hold indefinitely.
  - start is ignored in DONE. It is honoured only in IDLE, including the cycle after the out_ready handshake.
- Timing:
  - sum updates one clock after each transfer.
  - out_valid rises the clock after the final transfer.
  - Minimum burst is COUNT+2 cycles from start to IDLE (start, COUNT transfers, handshake).
- sum remains readable in IDLE until the next start clears it.
- COUNT = 1: the first transfer goes straight to DONE.
- Counter width is ceil(log2(COUNT+1)), minimum 1 bit.

Test Plan:
- Reset, then start. Transfer 100, 255, 39, 24, all with op = 0, in_valid held high -> sum = 162 (418 mod 256), carry = 1, out_valid high on the 5th clock after start. The bench holds out_ready low for 3 cycles: sum must stay at 162, and in_ready = 0 throughout.
- start. Transfer 10 add, 20 add, 5 sub, 1 add -> sum = 26, carry = 0. Assert out_ready -> IDLE next cycle, out_valid = 0, sum still 26.
- start. Transfer 100 sub (0 - 100), then 0 add, 0 add, 0 add -> sum = 156, carry = 1 (borrow).
- Gaps and ignored inputs:
  - in_valid toggles 1,0,0,1,1,0,1 carrying 1,9,9,2,3,9,4; only the valid beats count -> sum = 10.
  - start pulsed during ACCUM and during DONE -> no effect.
  - in_valid with start in IDLE -> no operand consumed.
- Drop rst_n low asynchronously, between clock edges, after 2 transfers -> immediately: out_valid = 0, in_ready = 0, sum = 0, carry = 0, busy = 0. After release, a new burst gives the correct result.
